fsm_cmd_sequencer: RTL and testbench

- Host-side command driver for `fsm_core`; the initiator end of the `in_signal`/`out_signal` control interface.
- Accepts one control command at a time over a valid/ready handshake and drives it onto the FSM command input.
- Watches the FSM state output until the expected target state appears, then returns a status response over a second valid/ready handshake.
- Replaces hand-timed stimulus: callers never need to know FSM latency.

---
 rtl/fsm_cmd_sequencer.sv | 145 ++++++++++++++
 tb/tb_fsm_cmd_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_cmd_sequencer.sv
// fsm_cmd_sequencer: host-side command driver for fsm_core.
// Accepts one control command at a time. It drives the command onto fsm_in,
// then watches fsm_state until the command's target state appears. It then
// returns a status response.
// Optional feature macro: FSM_SEQ_TIMEOUT_EN. When it is defined, a bounded
// wait is compiled in, and a TIMEOUT status is reported after TIMEOUT_CYCLES
// cycles spent in S_WAIT.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. The sequencer never waits on cmd_valid before raising cmd_ready.
// Once resp_valid rises, resp_status and resp_state hold stable until the
// edge on which resp_ready is also high.
module fsm_cmd_sequencer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_code,
  output logic [1:0] fsm_in,
  input  logic [1:0] fsm_state,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic [1:0] resp_status,
  output logic [1:0] resp_state,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_ILLEGAL = 2'b10;
  localparam logic [1:0] CMD_ILLEGAL = 2'b11;

  // Elaboration-time guard on the legal range of the timeout length.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("fsm_cmd_sequencer: TIMEOUT_CYCLES must be >= 1");
  end

  state_t     state_q, state_d;
  logic [1:0] fsm_in_q, fsm_in_d;
  logic [1:0] target_q, target_d;
  logic [1:0] status_q, status_d;
  logic [1:0] rstate_q, rstate_d;

`ifdef FSM_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  assign cmd_ready   = (state_q == S_IDLE);
  assign resp_valid  = (state_q == S_RESP);
  assign busy        = (state_q != S_IDLE);
  assign fsm_in      = fsm_in_q;
  assign resp_status = status_q;
  assign resp_state  = rstate_q;

  // Next-state and datapath: accept, wait for the target state, then respond.
  always_comb begin
    state_d  = state_q;
    fsm_in_d = fsm_in_q;
    target_d = target_q;
    status_d = status_q;
    rstate_d = rstate_q;
`ifdef FSM_SEQ_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if (cmd_code == CMD_ILLEGAL) begin
            // The illegal code never reaches the FSM; fsm_in keeps the last legal command.
            status_d = ST_ILLEGAL;
            rstate_d = fsm_state;
            state_d  = S_RESP;
          end else begin
            // Each legal code names its own target state.
            fsm_in_d = cmd_code;
            target_d = cmd_code;
`ifdef FSM_SEQ_TIMEOUT_EN
            cnt_d    = '0;
`endif
            state_d  = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // A match takes priority over the limit, so a late match still reports OK.
        if (fsm_state == target_q) begin
          status_d = ST_OK;
          rstate_d = fsm_state;
          state_d  = S_RESP;
        end
`ifdef FSM_SEQ_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          status_d = ST_TIMEOUT;
          rstate_d = fsm_state;
          state_d  = S_RESP;
        end else begin
          // The limit check comes first, so the counter never wraps.
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      S_RESP: begin
        if (resp_valid && resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers. A synchronous reset drops any
  // in-flight work and forces the FSM command back to IDLE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      fsm_in_q <= 2'b00;
      target_q <= 2'b00;
      status_q <= 2'b00;
      rstate_q <= 2'b00;
`ifdef FSM_SEQ_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      fsm_in_q <= fsm_in_d;
      target_q <= target_d;
      status_q <= status_d;
      rstate_q <= rstate_d;
`ifdef FSM_SEQ_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_fsm_cmd_sequencer.sv
// Testbench for fsm_cmd_sequencer. An fsm_core stand-in follows fsm_in
// after a programmable extra delay. The expected latency, status and
// resp_state of each command come from a latency model of that stand-in.
module tb_fsm_cmd_sequencer;

  localparam int T = 4;
`ifdef FSM_SEQ_TIMEOUT_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif
  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_ILLEGAL = 2'b10;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  always #5 clk = ~clk;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_code;
  logic [1:0] fsm_in;
  logic [1:0] fsm_state;
  logic       resp_valid;
  logic       resp_ready;
  logic [1:0] resp_status;
  logic [1:0] resp_state;
  logic       busy;

  fsm_cmd_sequencer #(.TIMEOUT_CYCLES(T)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_code   (cmd_code),
    .fsm_in     (fsm_in),
    .fsm_state  (fsm_state),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_status(resp_status),
    .resp_state (resp_state),
    .busy       (busy)
  );

  // fsm_core stand-in: adopts fsm_in after stub_delay extra cycles.
  // A huge delay acts as a stuck FSM.
  int stub_delay;
  int wait_cnt;
  always @(posedge clk) begin
    if (!reset) begin
      fsm_state <= 2'b00;
      wait_cnt  <= 0;
    end else if (fsm_state == fsm_in) begin
      wait_cnt <= 0;
    end else if (wait_cnt >= stub_delay) begin
      fsm_state <= fsm_in;
      wait_cnt  <= 0;
    end else begin
      wait_cnt <= wait_cnt + 1;
    end
  end

  // ---------------- scoreboard ----------------
  logic [3:0] exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [1:0] m_cur;
  logic [1:0] m_fsm_in;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Issue one command, then take its response after `stall` cycles of backpressure.
  task automatic run_cmd(input logic [1:0] code, input int d, input int stall, input bit junk);
    int         lat_exp;
    int         n;
    logic [1:0] st_exp, rs_exp, fin_exp;
    logic [3:0] exp_r;
    bit         timed_out;
    timed_out = 1'b0;
    exp_r     = 4'h0;
    if (code == 2'b11) begin
      lat_exp = 0;
      st_exp  = ST_ILLEGAL;
      rs_exp  = m_cur;
      fin_exp = m_fsm_in;
    end else begin
      lat_exp = (m_cur == code) ? 1 : d + 2;
      fin_exp = code;
      if (TEN && lat_exp > T) begin
        lat_exp   = T;
        st_exp    = ST_TIMEOUT;
        rs_exp    = m_cur;
        timed_out = 1'b1;
      end else begin
        st_exp = ST_OK;
        rs_exp = code;
      end
    end
    exp_q.push_back({st_exp, rs_exp});

    stub_delay = d;
    cmd_code   = code;
    cmd_valid  = 1'b1;
    @(posedge clk); #1;
    // Optional junk command while busy: it must not be consumed.
    cmd_valid = junk;
    cmd_code  = 2'($urandom_range(0, 3));
    check("fsm_in_after_accept", {6'd0, fsm_in}, {6'd0, fin_exp});

    n = 0;
    while (!resp_valid && n < 60) begin
      check("cmd_ready_low_in_wait", {7'd0, cmd_ready}, 8'd0);
      check("busy_in_wait", {7'd0, busy}, 8'd1);
      @(posedge clk); #1;
      n++;
    end
    cmd_valid = 1'b0;
    check("resp_latency", 8'(n), 8'(lat_exp));
    if (exp_q.size() > 0) begin
      exp_r = exp_q.pop_front();
      check("resp_status_state", {4'd0, resp_status, resp_state}, {4'd0, exp_r});
    end

    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check("resp_valid_held", {7'd0, resp_valid}, 8'd1);
      check("resp_stable", {4'd0, resp_status, resp_state}, {4'd0, exp_r});
      check("cmd_ready_low_stalled", {7'd0, cmd_ready}, 8'd0);
    end

    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("resp_valid_dropped", {7'd0, resp_valid}, 8'd0);
    check("cmd_ready_after_resp", {7'd0, cmd_ready}, 8'd1);
    check("busy_after_resp", {7'd0, busy}, 8'd0);
    check("fsm_in_sticky", {6'd0, fsm_in}, {6'd0, fin_exp});

    m_fsm_in = fin_exp;
    if (code != 2'b11) m_cur = code;
    if (timed_out) begin
      stub_delay = 0;
      repeat (6) @(posedge clk);
      #1;
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [1:0] c;
    int         n;
    reset      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_code   = 2'b00;
    resp_ready = 1'b0;
    stub_delay = 0;
    m_cur      = 2'b00;
    m_fsm_in   = 2'b00;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", {7'd0, cmd_ready}, 8'd1);
    check("rst_fsm_in", {6'd0, fsm_in}, 8'd0);
    check("rst_resp_valid", {7'd0, resp_valid}, 8'd0);
    check("rst_busy", {7'd0, busy}, 8'd0);
    check("rst_resp_fields", {4'd0, resp_status, resp_state}, 8'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("idle_cmd_ready", {7'd0, cmd_ready}, 8'd1);
    check("idle_resp_valid", {7'd0, resp_valid}, 8'd0);

    // START from IDLE with a one-cycle FSM.
    run_cmd(2'b01, 0, 0, 1'b0);
    // START, STOP, IDLE with 3 cycles of response backpressure each.
    run_cmd(2'b01, 0, 3, 1'b1);
    run_cmd(2'b10, 0, 3, 1'b1);
    run_cmd(2'b00, 0, 3, 1'b1);
    // Illegal code while fsm_in = 01.
    run_cmd(2'b01, 1, 0, 1'b0);
    run_cmd(2'b11, 0, 1, 1'b0);
    // Target already present.
    run_cmd(2'b01, 0, 0, 1'b0);

    // FSM stuck at IDLE while a STOP is outstanding.
    run_cmd(2'b00, 0, 0, 1'b0);
`ifdef FSM_SEQ_TIMEOUT_EN
    run_cmd(2'b10, 1000, 1, 1'b0);
    // Match arriving on the same cycle as the limit: OK wins.
    run_cmd(2'b01, T - 2, 0, 1'b0);
`else
    stub_delay = 1000;
    cmd_code   = 2'b10;
    cmd_valid  = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("stuck_fsm_in", {6'd0, fsm_in}, 8'h02);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      check("stuck_no_resp", {7'd0, resp_valid}, 8'd0);
    end
    stub_delay = 0;
    n = 0;
    while (!resp_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("unstuck_latency", 8'(n), 8'd2);
    check("unstuck_resp", {4'd0, resp_status, resp_state}, {4'd0, ST_OK, 2'b10});
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("unstuck_idle", {7'd0, cmd_ready}, 8'd1);
    m_cur    = 2'b10;
    m_fsm_in = 2'b10;
`endif

    // Reset while in S_WAIT.
    c          = (m_cur == 2'b01) ? 2'b10 : 2'b01;
    stub_delay = 1000;
    cmd_code   = c;
    cmd_valid  = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("midop_busy", {7'd0, busy}, 8'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    check("midop_rst_cmd_ready", {7'd0, cmd_ready}, 8'd1);
    check("midop_rst_fsm_in", {6'd0, fsm_in}, 8'd0);
    check("midop_rst_busy", {7'd0, busy}, 8'd0);
    check("midop_rst_resp_valid", {7'd0, resp_valid}, 8'd0);
    reset      = 1'b1;
    stub_delay = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("midop_no_resp", {7'd0, resp_valid}, 8'd0);
    end
    m_cur    = 2'b00;
    m_fsm_in = 2'b00;

    // Randomized commands, FSM delays, backpressure and gaps.
    for (int i = 0; i < 40; i++) begin
      c = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      check("gap_cmd_ready", {7'd0, cmd_ready}, 8'd1);
      run_cmd(c, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    check("scoreboard_empty", 8'(exp_q.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
